// File: rtl/cdcc_pkg.sv
// Shared definitions for the dilated convolution cache and its downstream
// convolution stages: default sample width and the cache sequencing states.
package cdcc_pkg;

  localparam int DEFAULT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_OUTPUT = 2'd2
  } cache_state_e;

endpackage

// File: rtl/cache_ring_buffer.sv
// Ring storage for the activation cache: one synchronous write port and three
// asynchronous read ports, each word holding one 4-channel sample {d3,d2,d1,d0}.
// Contents are not reset; the fill counter in the parent masks stale slots.
module cache_ring_buffer
  import cdcc_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int DEPTH = 4,
  parameter int PW    = 2
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [PW-1:0]   waddr_i,
  input  logic [4*W-1:0]  wdata_i,
  input  logic [PW-1:0]   raddr0_i,
  input  logic [PW-1:0]   raddr1_i,
  input  logic [PW-1:0]   raddr2_i,
  output logic [4*W-1:0]  rdata0_o,
  output logic [4*W-1:0]  rdata1_o,
  output logic [4*W-1:0]  rdata2_o
);

  logic [4*W-1:0] mem_q [DEPTH];

  // Single write port, written once per accepted sample.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];

endmodule

// File: rtl/dilated_activation_cache.sv
// Dilated activation cache: keeps the last 3*DILATION+1 four-channel samples
// and presents four taps x[t], x[t-D], x[t-2D], x[t-3D] per accepted sample.
// Taps referring to never-written slots read as zero.
// Optional build macro CACHE_WARMUP_HOLD_EN: suppresses out_v until the cache
// holds a full window (first pulse for sample index 3*DILATION).
module dilated_activation_cache
  import cdcc_pkg::*;
#(
  parameter int W        = DEFAULT_W,
  parameter int DILATION = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] inp_d0,
  input  logic signed [W-1:0] inp_d1,
  input  logic signed [W-1:0] inp_d2,
  input  logic signed [W-1:0] inp_d3,
  input  logic                inp_v,
  output logic signed [W-1:0] a0_d0,
  output logic signed [W-1:0] a0_d1,
  output logic signed [W-1:0] a0_d2,
  output logic signed [W-1:0] a0_d3,
  output logic signed [W-1:0] a1_d0,
  output logic signed [W-1:0] a1_d1,
  output logic signed [W-1:0] a1_d2,
  output logic signed [W-1:0] a1_d3,
  output logic signed [W-1:0] a2_d0,
  output logic signed [W-1:0] a2_d1,
  output logic signed [W-1:0] a2_d2,
  output logic signed [W-1:0] a2_d3,
  output logic signed [W-1:0] a3_d0,
  output logic signed [W-1:0] a3_d1,
  output logic signed [W-1:0] a3_d2,
  output logic signed [W-1:0] a3_d3,
  output logic                out_v,
  output logic                busy,
  output logic                overrun
);

  localparam int DEPTH = 3 * DILATION + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [PW-1:0] FILL_MAX = PW'(3 * DILATION);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  cache_state_e   state_q;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  fill_q, fill_d;
  logic [4*W-1:0] in_q;
  logic [4*W-1:0] tap_q [4];
  logic [4*W-1:0] tap_d [4];
  logic [4*W-1:0] rd    [3];
  logic [PW-1:0]  raddr [3];
  logic           out_v_q, busy_q, overrun_q;
  logic           pulse_d;
  logic           ring_we;

  // (ptr - off) mod DEPTH; off never exceeds DEPTH-1 so one correction suffices.
  // When DEPTH is a power of two the PW-bit wrap of DEPTH to zero is still exact.
  function automatic logic [PW-1:0] tap_addr(input logic [PW-1:0] ptr,
                                             input logic [PW-1:0] off);
    if (ptr >= off) return ptr - off;
    else            return ptr + (PW'(DEPTH) - off);
  endfunction

  assign ring_we = (state_q == ST_WRITE);

  cache_ring_buffer #(
    .W     (W),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ring (
    .clk      (clk),
    .we_i     (ring_we),
    .waddr_i  (wr_ptr_q),
    .wdata_i  (in_q),
    .raddr0_i (raddr[0]),
    .raddr1_i (raddr[1]),
    .raddr2_i (raddr[2]),
    .rdata0_o (rd[0]),
    .rdata1_o (rd[1]),
    .rdata2_o (rd[2])
  );

  // Tap addresses, zero-masking of unwritten slots, and pointer/fill advance.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      raddr[k] = tap_addr(wr_ptr_q, PW'((3 - k) * DILATION));
      tap_d[k] = (fill_q < PW'((3 - k) * DILATION)) ? '0 : rd[k];
    end
    tap_d[3] = in_q;
    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
`ifdef CACHE_WARMUP_HOLD_EN
    pulse_d  = (fill_q == FILL_MAX);
`else
    pulse_d  = 1'b1;
`endif
  end

  // Input sample register; pure data, loaded when a sample is accepted.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && inp_v) in_q <= {inp_d3, inp_d2, inp_d1, inp_d0};
  end

  // Sequencer IDLE -> WRITE -> OUTPUT -> IDLE with registered flags and taps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      out_v_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int k = 0; k < 4; k++) tap_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_v_q <= 1'b0;
          if (inp_v) begin
            state_q <= ST_WRITE;
            busy_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          for (int k = 0; k < 4; k++) tap_q[k] <= tap_d[k];
          wr_ptr_q <= wr_ptr_d;
          fill_q   <= fill_d;
          out_v_q  <= pulse_d;
          state_q  <= ST_OUTPUT;
          busy_q   <= 1'b1;
          if (inp_v) overrun_q <= 1'b1;
        end
        ST_OUTPUT: begin
          out_v_q <= 1'b0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          if (inp_v) overrun_q <= 1'b1;
        end
        default: begin
          out_v_q <= 1'b0;
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_v   = out_v_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

  assign a0_d0 = tap_q[0][W-1:0];
  assign a0_d1 = tap_q[0][2*W-1:W];
  assign a0_d2 = tap_q[0][3*W-1:2*W];
  assign a0_d3 = tap_q[0][4*W-1:3*W];
  assign a1_d0 = tap_q[1][W-1:0];
  assign a1_d1 = tap_q[1][2*W-1:W];
  assign a1_d2 = tap_q[1][3*W-1:2*W];
  assign a1_d3 = tap_q[1][4*W-1:3*W];
  assign a2_d0 = tap_q[2][W-1:0];
  assign a2_d1 = tap_q[2][2*W-1:W];
  assign a2_d2 = tap_q[2][3*W-1:2*W];
  assign a2_d3 = tap_q[2][4*W-1:3*W];
  assign a3_d0 = tap_q[3][W-1:0];
  assign a3_d1 = tap_q[3][2*W-1:W];
  assign a3_d2 = tap_q[3][3*W-1:2*W];
  assign a3_d3 = tap_q[3][4*W-1:3*W];

endmodule

// File: tb/tb_dilated_activation_cache.sv
// Directed bench: instance A uses DILATION=2, instance B uses DILATION=1.
module tb_dilated_activation_cache;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, v_a, v_b;
  logic signed [15:0] in_a [4];
  logic signed [15:0] in_b [4];
  logic signed [15:0] ta [4][4];
  logic signed [15:0] tb [4][4];
  logic ov_a, ov_b, busy_a, busy_b, orun_a, orun_b;
  logic p_w, p_p, p_b;
  int checks = 0;
  int errors = 0;

  dilated_activation_cache #(.W(16), .DILATION(2)) dut_a (
    .clk(clk), .rst(rst_a),
    .inp_d0(in_a[0]), .inp_d1(in_a[1]), .inp_d2(in_a[2]), .inp_d3(in_a[3]),
    .inp_v(v_a),
    .a0_d0(ta[0][0]), .a0_d1(ta[0][1]), .a0_d2(ta[0][2]), .a0_d3(ta[0][3]),
    .a1_d0(ta[1][0]), .a1_d1(ta[1][1]), .a1_d2(ta[1][2]), .a1_d3(ta[1][3]),
    .a2_d0(ta[2][0]), .a2_d1(ta[2][1]), .a2_d2(ta[2][2]), .a2_d3(ta[2][3]),
    .a3_d0(ta[3][0]), .a3_d1(ta[3][1]), .a3_d2(ta[3][2]), .a3_d3(ta[3][3]),
    .out_v(ov_a), .busy(busy_a), .overrun(orun_a)
  );

  dilated_activation_cache #(.W(16), .DILATION(1)) dut_b (
    .clk(clk), .rst(rst_b),
    .inp_d0(in_b[0]), .inp_d1(in_b[1]), .inp_d2(in_b[2]), .inp_d3(in_b[3]),
    .inp_v(v_b),
    .a0_d0(tb[0][0]), .a0_d1(tb[0][1]), .a0_d2(tb[0][2]), .a0_d3(tb[0][3]),
    .a1_d0(tb[1][0]), .a1_d1(tb[1][1]), .a1_d2(tb[1][2]), .a1_d3(tb[1][3]),
    .a2_d0(tb[2][0]), .a2_d1(tb[2][1]), .a2_d2(tb[2][2]), .a2_d3(tb[2][3]),
    .a3_d0(tb[3][0]), .a3_d1(tb[3][1]), .a3_d2(tb[3][2]), .a3_d3(tb[3][3]),
    .out_v(ov_b), .busy(busy_b), .overrun(orun_b)
  );

  // Stimulus only: one sample, then record out_v in WRITE, in OUTPUT, and busy after.
  task automatic push(input bit sel, input int d0, input int d1, input int d2, input int d3);
    @(negedge clk);
    if (!sel) begin
      in_a[0] = 16'(d0); in_a[1] = 16'(d1); in_a[2] = 16'(d2); in_a[3] = 16'(d3); v_a = 1'b1;
    end else begin
      in_b[0] = 16'(d0); in_b[1] = 16'(d1); in_b[2] = 16'(d2); in_b[3] = 16'(d3); v_b = 1'b1;
    end
    @(negedge clk);
    v_a = 1'b0; v_b = 1'b0;
    p_w = sel ? ov_b : ov_a;
    @(negedge clk);
    p_p = sel ? ov_b : ov_a;
    @(negedge clk);
    p_b = sel ? busy_b : busy_a;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; v_a = 1'b0; v_b = 1'b0;
    for (int c = 0; c < 4; c++) begin in_a[c] = '0; in_b[c] = '0; end
    repeat (2) @(negedge clk);
    checks++; if (ov_a !== 1'b0 || ov_b !== 1'b0) begin errors++; $display("FAIL reset_out_v got %b/%b want 0/0", ov_a, ov_b); end
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b want 0/0", busy_a, busy_b); end
    checks++; if (orun_a !== 1'b0 || orun_b !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b/%b want 0/0", orun_a, orun_b); end
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (ta[k][c] !== 16'sd0 || tb[k][c] !== 16'sd0) begin
          errors++; $display("FAIL reset_tap a%0d_d%0d got %0d/%0d want 0", k, c, ta[k][c], tb[k][c]);
        end
      end
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_warmup();
    int e;
    logic want_p;
    for (int n = 1; n <= 7; n++) begin
      push(1'b0, n, n + 100, n + 200, n + 300);
`ifdef CACHE_WARMUP_HOLD_EN
      want_p = (n == 7);
`else
      want_p = 1'b1;
`endif
      checks++; if (p_w !== 1'b0) begin errors++; $display("FAIL warmup_write_quiet n=%0d got %b want 0", n, p_w); end
      checks++; if (p_p !== want_p) begin errors++; $display("FAIL warmup_out_v n=%0d got %b want %b", n, p_p, want_p); end
      checks++; if (p_b !== 1'b0) begin errors++; $display("FAIL warmup_busy_end n=%0d got %b want 0", n, p_b); end
      for (int k = 0; k < 4; k++)
        for (int c = 0; c < 4; c++) begin
          e = n - (3 - k) * 2;
          e = (e >= 1) ? e + c * 100 : 0;
          checks++;
          if (ta[k][c] !== 16'(e)) begin
            errors++; $display("FAIL warmup_tap n=%0d a%0d_d%0d got %0d want %0d", n, k, c, ta[k][c], e);
          end
        end
    end
  endtask

  task automatic test_overrun();
    @(negedge clk);
    for (int c = 0; c < 4; c++) in_a[c] = 16'(8 + c * 100);
    v_a = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) in_a[c] = 16'sd999;
    @(negedge clk);
    v_a = 1'b0;
    checks++; if (ov_a !== 1'b1) begin errors++; $display("FAIL overrun_out_v got %b want 1", ov_a); end
    checks++; if (orun_a !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", orun_a); end
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (ta[k][c] !== 16'(2 + 2 * k + c * 100)) begin
          errors++; $display("FAIL overrun_tap8 a%0d_d%0d got %0d want %0d", k, c, ta[k][c], 2 + 2 * k + c * 100);
        end
      end
    push(1'b0, 9, 109, 209, 309);
    checks++; if (p_p !== 1'b1) begin errors++; $display("FAIL overrun_next_out_v got %b want 1", p_p); end
    checks++; if (orun_a !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", orun_a); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ta[k][0] !== 16'(3 + 2 * k)) begin
        errors++; $display("FAIL overrun_tap9 a%0d_d0 got %0d want %0d", k, ta[k][0], 3 + 2 * k);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic want_p;
    @(negedge clk);
    for (int c = 0; c < 4; c++) in_a[c] = 16'(50 + c);
    v_a = 1'b1;
    @(negedge clk);
    v_a = 1'b0;
    rst_a = 1'b1;
    #1;
    checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rstmid_out_v got %b want 0", ov_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy_a); end
    checks++; if (orun_a !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b want 0", orun_a); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ta[k][0] !== 16'sd0) begin errors++; $display("FAIL rstmid_tap a%0d_d0 got %0d want 0", k, ta[k][0]); end
    end
    @(negedge clk);
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ov_a !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse cyc=%0d got %b want 0", i, ov_a); end
    end
    push(1'b0, 11, 111, 211, 311);
`ifdef CACHE_WARMUP_HOLD_EN
    want_p = 1'b0;
`else
    want_p = 1'b1;
`endif
    checks++; if (p_p !== want_p) begin errors++; $display("FAIL rstmid_first_out_v got %b want %b", p_p, want_p); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (ta[3][c] !== 16'(11 + c * 100) || ta[0][c] !== 16'sd0 || ta[1][c] !== 16'sd0 || ta[2][c] !== 16'sd0) begin
        errors++; $display("FAIL rstmid_first_taps d%0d got %0d %0d %0d %0d want 0 0 0 %0d", c,
                           ta[0][c], ta[1][c], ta[2][c], ta[3][c], 11 + c * 100);
      end
    end
  endtask

  task automatic test_wrap();
    logic want_p;
    for (int n = 1; n <= 20; n++) begin
      push(1'b1, n, n + 100, n + 200, n + 300);
`ifdef CACHE_WARMUP_HOLD_EN
      want_p = (n >= 4);
`else
      want_p = 1'b1;
`endif
      checks++; if (p_p !== want_p) begin errors++; $display("FAIL wrap_out_v n=%0d got %b want %b", n, p_p, want_p); end
    end
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 4; c++) begin
        checks++;
        if (tb[k][c] !== 16'(17 + k + c * 100)) begin
          errors++; $display("FAIL wrap_tap a%0d_d%0d got %0d want %0d", k, c, tb[k][c], 17 + k + c * 100);
        end
      end
  endtask

  task automatic test_signed();
    int s [4];
    s[0] = -32768; s[1] = 32767; s[2] = -32768; s[3] = 32767;
    push(1'b1, s[0], s[1], s[2], s[3]);
    checks++; if (p_w !== 1'b0) begin errors++; $display("FAIL signed_latency_early got %b want 0", p_w); end
    checks++; if (p_p !== 1'b1) begin errors++; $display("FAIL signed_latency_pulse got %b want 1", p_p); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tb[3][c] !== 16'(s[c]) || tb[2][c] !== 16'(20 + c * 100)) begin
        errors++; $display("FAIL signed_tap1 d%0d got a3=%0d a2=%0d want a3=%0d a2=%0d", c, tb[3][c], tb[2][c], s[c], 20 + c * 100);
      end
    end
    push(1'b1, s[1], s[0], s[1], s[0]);
    checks++; if (p_p !== 1'b1) begin errors++; $display("FAIL signed_second_pulse got %b want 1", p_p); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (tb[3][c] !== 16'(s[c ^ 1]) || tb[2][c] !== 16'(s[c]) || tb[1][c] !== 16'(20 + c * 100)) begin
        errors++; $display("FAIL signed_tap2 d%0d got a3=%0d a2=%0d a1=%0d want %0d %0d %0d", c,
                           tb[3][c], tb[2][c], tb[1][c], s[c ^ 1], s[c], 20 + c * 100);
      end
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_overrun();
    test_reset_mid();
    test_wrap();
    test_signed();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
